// File: rtl/debug_dump_sequencer_pkg.sv
// Shared definitions for the debug dump sequencer.
// Contents:
//   - state_t   : 3-bit FSM encoding, shared by the top and the word serializer
//   - section_t : 2-bit dump section codes, in the order they are streamed
//   - default geometry constants and the bytes-per-word helper
package debug_dump_sequencer_pkg;

   localparam int BITS_SIZE_DEF     = 32;
   localparam int SIZE_TRAMA_DEF    = 8;
   localparam int NUM_REGS_DEF      = 32;
   localparam int SIZE_MEM_DATA_DEF = 16;

   localparam int BYTES_PER_WORD = BITS_SIZE_DEF / SIZE_TRAMA_DEF;
   localparam int TOTAL_WORDS    = 2 + NUM_REGS_DEF + SIZE_MEM_DATA_DEF;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LOAD = 3'd1,
      ST_SEND = 3'd2,
      ST_WAIT = 3'd3,
      ST_NEXT = 3'd4,
      ST_DONE = 3'd5
   } state_t;

   typedef enum logic [1:0] {
      SEC_PC  = 2'd0,
      SEC_CNT = 2'd1,
      SEC_REG = 2'd2,
      SEC_MEM = 2'd3
   } section_t;

   function automatic int bytes_per_word(input int bits, input int trama);
      return bits / trama;
   endfunction

endpackage

// File: rtl/debug_dump_sequencer_serializer.sv
// dump_word_serializer: sends one BITS_SIZE word as SIZE_TRAMA-wide UART
// frames, least significant frame first, using a start/done handshake.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   load        : one-cycle pulse capturing word (accepted only when idle)
//   word        : word to serialize
//   tx_done     : UART frame-complete pulse (honoured only while waiting)
//   tx_start    : one-cycle UART start pulse
//   tx_data     : current frame, stable from tx_start until tx_done
//   word_done   : one-cycle pulse with the tx_done of the last frame
module dump_word_serializer
   import debug_dump_sequencer_pkg::*;
#(
   parameter int BITS_SIZE  = 32,
   parameter int SIZE_TRAMA = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  load,
   input  logic [BITS_SIZE-1:0]  word,
   input  logic                  tx_done,
   output logic                  tx_start,
   output logic [SIZE_TRAMA-1:0] tx_data,
   output logic                  word_done
);

   localparam int BPW   = bytes_per_word(BITS_SIZE, SIZE_TRAMA);
   localparam int CNT_W = (BPW > 1) ? $clog2(BPW) : 1;
   localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BPW - 1);

   state_t               state, state_next;
   logic [BITS_SIZE-1:0] shift, shift_next;
   logic [CNT_W-1:0]     byte_cnt, byte_cnt_next;

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_IDLE;
         shift    <= '0;
         byte_cnt <= '0;
      end else begin
         state    <= state_next;
         shift    <= shift_next;
         byte_cnt <= byte_cnt_next;
      end
   end

   always_comb begin
      state_next    = state;
      shift_next    = shift;
      byte_cnt_next = byte_cnt;
      tx_start      = 1'b0;
      word_done     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (load) begin
               shift_next    = word;
               byte_cnt_next = '0;
               state_next    = ST_SEND;
            end
         end
         ST_SEND: begin
            tx_start   = 1'b1;
            state_next = ST_WAIT;
         end
         ST_WAIT: begin
            if (tx_done) begin
               if (byte_cnt == LAST_BYTE) begin
                  // Shift is left as-is so tx_data keeps the last frame
                  // until the next word is loaded.
                  byte_cnt_next = '0;
                  word_done     = 1'b1;
                  state_next    = ST_IDLE;
               end else begin
                  byte_cnt_next = byte_cnt + 1'b1;
                  shift_next    = shift >> SIZE_TRAMA;
                  state_next    = ST_SEND;
               end
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   assign tx_data = shift[SIZE_TRAMA-1:0];

endmodule

// File: rtl/debug_dump_sequencer.sv
// debug_dump_sequencer: on request, streams PC, cycle counter, every
// register-file entry and the first SIZE_MEM_DATA data-memory words over the
// UART transmitter, LSB frame first.
// Ports:
//   i_clk, i_reset          : clock, synchronous active-high reset
//   i_start                 : dump request, sampled only when idle
//   i_pc, i_clk_count       : PC and cycle-counter words
//   i_data_reg_file         : register selected by o_select_register_dir
//   i_data_mem              : data word selected by o_select_mem_dir
//   i_tx_done               : UART frame-complete pulse
//   o_tx_start, o_tx_data   : UART start pulse and frame
//   o_select_register_dir   : register read index
//   o_select_mem_dir        : data-memory word index (zero-extended)
//   o_busy                  : dump in progress
//   o_done                  : one-cycle pulse at dump end
module debug_dump_sequencer
   import debug_dump_sequencer_pkg::*;
#(
   parameter int BITS_SIZE     = BITS_SIZE_DEF,
   parameter int SIZE_TRAMA    = SIZE_TRAMA_DEF,
   parameter int NUM_REGS      = NUM_REGS_DEF,
   parameter int SIZE_MEM_DATA = SIZE_MEM_DATA_DEF
) (
   input  logic                        i_clk,
   input  logic                        i_reset,
   input  logic                        i_start,
   input  logic [BITS_SIZE-1:0]        i_pc,
   input  logic [BITS_SIZE-1:0]        i_clk_count,
   input  logic [BITS_SIZE-1:0]        i_data_reg_file,
   input  logic [BITS_SIZE-1:0]        i_data_mem,
   input  logic                        i_tx_done,
   output logic                        o_tx_start,
   output logic [SIZE_TRAMA-1:0]       o_tx_data,
   output logic [$clog2(NUM_REGS)-1:0] o_select_register_dir,
   output logic [BITS_SIZE-1:0]        o_select_mem_dir,
   output logic                        o_busy,
   output logic                        o_done
);

   localparam int REG_W = $clog2(NUM_REGS);
   localparam logic [REG_W-1:0]     REG_LAST = REG_W'(NUM_REGS - 1);
   localparam logic [BITS_SIZE-1:0] MEM_LAST = BITS_SIZE'(SIZE_MEM_DATA - 1);

   state_t               state, state_next;
   section_t             section, section_next;
   logic [REG_W-1:0]     reg_sel, reg_sel_next;
   logic [BITS_SIZE-1:0] mem_sel, mem_sel_next;
   logic                 load;
   logic [BITS_SIZE-1:0] word;
   logic                 word_done;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state   <= ST_IDLE;
         section <= SEC_PC;
         reg_sel <= '0;
         mem_sel <= '0;
      end else begin
         state   <= state_next;
         section <= section_next;
         reg_sel <= reg_sel_next;
         mem_sel <= mem_sel_next;
      end
   end

   // The selects double as the section indices, so the read ports always see
   // the word that the following LOAD will capture.
   always_comb begin
      state_next   = state;
      section_next = section;
      reg_sel_next = reg_sel;
      mem_sel_next = mem_sel;
      load         = 1'b0;
      case (state)
         ST_IDLE: begin
            if (i_start) begin
               section_next = SEC_PC;
               state_next   = ST_LOAD;
            end
         end
         ST_LOAD: begin
            load       = 1'b1;
            state_next = ST_WAIT;
         end
         // The serializer owns SEND/WAIT for the frames; here WAIT just
         // covers the whole word being in flight.
         ST_WAIT: begin
            if (word_done) state_next = ST_NEXT;
         end
         ST_NEXT: begin
            state_next = ST_LOAD;
            case (section)
               SEC_PC: section_next = SEC_CNT;
               SEC_CNT: begin
                  section_next = SEC_REG;
                  reg_sel_next = '0;
               end
               SEC_REG: begin
                  if (reg_sel == REG_LAST) begin
                     section_next = SEC_MEM;
                     mem_sel_next = '0;
                  end else begin
                     reg_sel_next = reg_sel + 1'b1;
                  end
               end
               default: begin
                  if (mem_sel == MEM_LAST) state_next = ST_DONE;
                  else mem_sel_next = mem_sel + 1'b1;
               end
            endcase
         end
         ST_DONE: state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      case (section)
         SEC_PC:  word = i_pc;
         SEC_CNT: word = i_clk_count;
         SEC_REG: word = i_data_reg_file;
         default: word = i_data_mem;
      endcase
   end

   dump_word_serializer #(
      .BITS_SIZE (BITS_SIZE),
      .SIZE_TRAMA(SIZE_TRAMA)
   ) u_serializer (
      .clk      (i_clk),
      .reset    (i_reset),
      .load     (load),
      .word     (word),
      .tx_done  (i_tx_done),
      .tx_start (o_tx_start),
      .tx_data  (o_tx_data),
      .word_done(word_done)
   );

   assign o_select_register_dir = reg_sel;
   assign o_select_mem_dir      = mem_sel;
   assign o_busy                = (state != ST_IDLE);
   assign o_done                = (state == ST_DONE);

endmodule

// File: doc/debug_dump_sequencer.md
# debug_dump_sequencer

Debug-readout controller that streams a complete MIPS state snapshot over the UART transmitter once triggered. It emits PC, the cycle counter, all register-file entries and the first SIZE_MEM_DATA data-memory words, in that order, four bytes per word, LSB first. It sits between the debug unit (trigger), the MIPS debug read ports (register/memory select and data), and the UART TX start/done handshake.

## Interface
Parameters:
- BITS_SIZE, 32, width of every dumped word (fixed at 4 frames of SIZE_TRAMA)
- SIZE_TRAMA, 8, UART frame width
- NUM_REGS, 32, register-file entries dumped
- SIZE_MEM_DATA, 16, data-memory words dumped

Ports:
- Clocking: one clock; reset is synchronous and active-high.
- i_clk  in  1  system clock
- i_reset  in  1  synchronous active-high reset
- i_start  in  1  dump request, sampled only in IDLE
- i_pc  in  BITS_SIZE  current MIPS PC
- i_clk_count  in  BITS_SIZE  executed-cycle counter
- i_data_reg_file  in  BITS_SIZE  register addressed by o_select_register_dir
- i_data_mem  in  BITS_SIZE  data word addressed by o_select_mem_dir
- i_tx_done  in  1  UART byte-complete pulse
- o_tx_start  out  1  one-cycle UART start pulse
- o_tx_data  out  SIZE_TRAMA  byte to send, held stable from SEND until i_tx_done
- o_select_register_dir  out  $clog2(NUM_REGS)  register read index
- o_select_mem_dir  out  BITS_SIZE  data-memory word index, zero-extended
- o_busy  out  1  high from LOAD through DONE
- o_done  out  1  one-cycle pulse at dump end

## Operation
- Sections, in order: SEC_PC (1 word), SEC_CNT (1 word), SEC_REG (NUM_REGS words, index 0 upward), SEC_MEM (SIZE_MEM_DATA words, index 0 upward). Default total is 50 words / 200 bytes.
- States: IDLE, LOAD, SEND, WAIT, NEXT, DONE.
  - IDLE: i_start=1 → LOAD. Section=SEC_PC, index=0, byte_cnt=0.
  - LOAD: latch the section's word into a BITS_SIZE shift register, then go to SEND.
  - SEND: o_tx_start=1 for exactly this cycle; o_tx_data=shift[7:0]. Next state is WAIT.
  - WAIT: hold until i_tx_done=1.
    - If byte_cnt==3: clear byte_cnt → NEXT.
    - Otherwise: byte_cnt+1, shift right by 8 → SEND.
  - NEXT: advance the index, rolling over into the next section. o_select_register_dir and o_select_mem_dir update here. If the last MEM word is complete → DONE, else LOAD.
  - DONE: o_done=1 for one cycle → IDLE.
- Selects hold their value outside SEC_REG/SEC_MEM. On entering SEC_REG and SEC_MEM they start at 0.

## Timing
- Reset values: state=IDLE; o_tx_start, o_busy and o_done are 0; o_tx_data=0; both selects=0; byte_cnt=0; shift=0.
- Trigger to first o_tx_start: 2 cycles (i_start edge → LOAD → SEND).
- i_tx_done to the next o_tx_start: 1 cycle within a word, 3 cycles across a word boundary (NEXT, LOAD, SEND).
- A select changes at the NEXT edge; its data is sampled at the following LOAD edge. Readers must therefore return valid data within one cycle (combinational or 1-cycle registered read).
- i_start is ignored outside IDLE. i_tx_done is ignored outside WAIT, including a done coinciding with SEND.
- i_reset has priority in every state. A mid-dump reset aborts immediately with no o_done, and all outputs return to reset values on the next edge.
- The last byte's i_tx_done is followed by NEXT → DONE, so o_done rises 2 cycles later.

## Structure
- Shared package holds:
  - state encoding localparams (3 bits)
  - section codes (2 bits)
  - BYTES_PER_WORD=BITS_SIZE/SIZE_TRAMA
  - total-word constant 2+NUM_REGS+SIZE_MEM_DATA
- One natural sub-module: dump_word_serializer, which owns shift/byte_cnt/SEND/WAIT and takes a word plus load pulse, returning word_done. The parent owns section/index sequencing.

## Test plan
- Reset, then i_start with i_tx_done returned 10 cycles after each o_tx_start → exactly 200 o_tx_start pulses, o_done once, o_busy low afterwards.
- i_pc=0x12345678, i_clk_count=0x000000A5 → first 8 bytes 78,56,34,12,A5,00,00,00.
- Register i returns 0xAA000000+i, memory j returns 0x5500_0000+j → bytes 8..11 are 00,00,00,AA and byte 136 is 00 (mem 0, LSB). Selects step 0..31 and 0..15.
- i_start pulsed while busy, plus a spurious i_tx_done during SEND → the byte stream is unchanged and the count stays 200.
- i_reset asserted after byte 57 → next cycle o_busy=0, selects=0, no o_done. A fresh i_start then restarts from the PC bytes.
- i_tx_done returned in the same cycle it becomes eligible (1 cycle after start) → back-to-back bytes 2 cycles apart within a word, 4 apart across words.
